fixed_mac_accum: RTL and testbench

FIXED_MAC_ACCUM -- requirements
Module: fixed_mac_accum

---
 rtl/fixed_mac_accum_pkg.sv | 33 +++
 rtl/fixed_mac_accum_mult.sv | 28 ++
 rtl/fixed_mac_accum.sv | 141 ++++++++++++++
 tb/tb_fixed_mac_accum.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_mac_accum_pkg.sv
// fixed_mac_accum shared package
// Q2.13 constants, stage-1 bundle and narrowing helpers
package fixed_mac_accum_pkg;

  localparam int FRAC_W = 13;
  localparam logic signed [31:0] RND_C = 32'sd4096;
  localparam logic signed [15:0] Q_MAX = 16'sh7fff;
  localparam logic signed [15:0] Q_MIN = 16'sh8000;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] prod;
  } s1_t;

  function automatic logic signed [15:0] sat16(
    input logic signed [31:0] v
  );
    if (v > 32'sd32767)
      return Q_MAX;
    else if (v < -32'sd32768)
      return Q_MIN;
    else
      return v[15:0];
  endfunction

  function automatic logic sat_hit(
    input logic signed [31:0] v
  );
    return (v > 32'sd32767) || (v < -32'sd32768);
  endfunction

endpackage

// File: rtl/fixed_mac_accum_mult.sv
// fixed_mac_accum combinational Q2.13 multiply
// round half-up, shift by FRAC_W, clamp to Q2.13
module fixed_mac_accum_mult
  import fixed_mac_accum_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
`ifdef FIXED_MAC_OVF_FLAG_EN
  output logic        ovf,
`endif
  output logic [15:0] p
);

  logic signed [31:0] full;
  logic signed [31:0] rnd;

  // full product, rounded and rescaled, then clamped
  always_comb begin
    full = 32'($signed(a)) * 32'($signed(b));
    rnd  = (full + RND_C) >>> FRAC_W;
    p    = sat16(rnd);
  end

`ifdef FIXED_MAC_OVF_FLAG_EN
  assign ovf = sat_hit(rnd);
`endif

endmodule

// File: rtl/fixed_mac_accum.sv
// fixed_mac_accum: two-stage saturating Q2.13 dot product
// optional sticky overflow flag: FIXED_MAC_OVF_FLAG_EN
module fixed_mac_accum
  import fixed_mac_accum_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf
);

  localparam logic [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  logic               en;
  logic [15:0]        prod;
  s1_t                s1;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W:0]     ext;
  logic [ACC_W:0]     sum_w;
  logic               acc_sat;
  logic [ACC_W-1:0]   sum_c;
  logic signed [31:0] sum32;
  logic [15:0]        out_nxt;
  logic               s2_fire;
  logic               s2_last;

  // a held result stalls the whole pipe
  assign in_ready = !(out_valid && !out_ready);
  assign en       = in_ready;
  assign s2_fire  = en && s1.valid;
  assign s2_last  = s2_fire && s1.last;

`ifdef FIXED_MAC_OVF_FLAG_EN
  logic prod_ovf;
  logic s1_ovf;
  logic sticky;
  logic nar_sat;
  logic beat_ovf;

  fixed_mac_accum_mult u_mult (
    .a   (in_a),
    .b   (in_b),
    .ovf (prod_ovf),
    .p   (prod)
  );
`else
  fixed_mac_accum_mult u_mult (
    .a (in_a),
    .b (in_b),
    .p (prod)
  );
`endif

  // stage 1: register product with its tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else if (en) begin
      s1.valid <= in_valid;
      if (in_valid) begin
        s1.last <= in_last;
        s1.prod <= prod;
      end
    end
  end

  // stage 2: widen, add, clamp, then narrow
  always_comb begin
    ext     = {{(ACC_W+1-16){s1.prod[15]}}, s1.prod};
    sum_w   = {acc[ACC_W-1], acc} + ext;
    acc_sat = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    sum_c   = sum_w[ACC_W-1:0];
    if (acc_sat)
      sum_c = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    sum32   = 32'($signed(sum_c));
    out_nxt = sat16(sum32);
  end

  // accumulator restarts after each last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (s2_fire)
      acc <= s1.last ? '0 : sum_c;
  end

  // result register; reload may overlap consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= s2_last;
      if (s2_last)
        out_data <= out_nxt;
    end
  end

`ifdef FIXED_MAC_OVF_FLAG_EN
  assign nar_sat  = sat_hit(sum32);
  assign beat_ovf = s1_ovf | acc_sat;

  // product clamp tag travels with stage 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      s1_ovf <= 1'b0;
    else if (en && in_valid)
      s1_ovf <= prod_ovf;
  end

  // sticky per-vector flag, published on last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky  <= 1'b0;
      out_ovf <= 1'b0;
    end else if (s2_fire) begin
      if (s1.last) begin
        sticky  <= 1'b0;
        out_ovf <= sticky | beat_ovf | nar_sat;
      end else begin
        sticky  <= sticky | beat_ovf;
      end
    end
  end
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fixed_mac_accum.sv
// tb_fixed_mac_accum: directed and random checks
// reference model works on plain integer arithmetic
module tb_fixed_mac_accum;

  localparam int ACC_W = 24;
`ifdef FIXED_MAC_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_ovf;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
  } res_t;

  res_t        expq[$];
  longint      macc = 0;
  bit          msticky = 0;
  bit          held = 0;
  logic [16:0] hold;

  always #5 clk = ~clk;

  fixed_mac_accum #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic longint clampv(input longint v,
                                    input longint lo,
                                    input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // reference: one accepted beat, in acceptance order
  task automatic model_beat(input logic [15:0] a,
                            input logic [15:0] b,
                            input logic last);
    longint amax, amin, p, s, n;
    bit po, ao, no;
    res_t r;
    amax = (longint'(1) << (ACC_W-1)) - 1;
    amin = -(longint'(1) << (ACC_W-1));
    p  = longint'($signed(a)) * longint'($signed(b));
    p  = (p + 4096) >>> 13;
    po = (p > 32767) || (p < -32768);
    p  = clampv(p, -32768, 32767);
    s  = macc + p;
    ao = (s > amax) || (s < amin);
    s  = clampv(s, amin, amax);
    if (last) begin
      no = (s > 32767) || (s < -32768);
      n  = clampv(s, -32768, 32767);
      r.data = n[15:0];
      r.ovf  = OVF_EN & (msticky | po | ao | no);
      expq.push_back(r);
      macc = 0;
      msticky = 0;
    end else begin
      macc = s;
      msticky = msticky | po | ao;
    end
  endtask

  // monitor: feeds model, checks results and stall hold
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      macc = 0;
      msticky = 0;
      expq.delete();
      held = 0;
    end else begin
      if (held)
        chk("stall_hold", {out_valid, out_ovf, out_data},
            {1'b1, hold});
      if (in_valid && in_ready)
        model_beat(in_a, in_b, in_last);
      if (out_valid && out_ready) begin
        tests++;
        assert (expq.size() > 0) else begin
          fails++;
          $error("FAIL unexpected_out: observed %h expected none",
                 out_data);
        end
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_ovf", out_ovf, e.ovf);
        end
        held = 0;
      end else if (out_valid) begin
        held = 1;
        hold = {out_ovf, out_data};
      end else begin
        held = 0;
      end
    end
  end

  task automatic send(input logic [15:0] a,
                      input logic [15:0] b,
                      input logic last,
                      input bit rnd);
    int n;
    bit ok;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    forever begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $error("FAIL send_timeout: observed stuck expected accept");
        break;
      end
    end
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    in_last = 1'($urandom);
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      in_last = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_res(input string tag,
                          input logic [15:0] d,
                          input logic o);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_ovf"}, out_ovf, o);
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 16'h7fff;
      1: return 16'h8000;
      2: return 16'h2000;
      3: return 16'he000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int len;
    int n;

    // reset values, including ready during reset
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", out_ovf, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // two-beat vector and its latency
    out_ready = 1'b1;
    send(16'h1000, 16'h2000, 1'b0, 1'b0);
    send(16'h1000, 16'h2000, 1'b1, 1'b0);
    chk("lat_early", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 16'h2000);
    chk("lat_ovf", out_ovf, 0);
    @(posedge clk);
    #1;

    // single beat, -1.0
    send(16'h2000, 16'he000, 1'b1, 1'b0);
    wait_res("single", 16'he000, 1'b0);
    @(posedge clk);
    #1;

    // four beats of 1.0 saturate the output
    for (int i = 0; i < 4; i++)
      send(16'h2000, 16'h2000, i == 3, 1'b0);
    wait_res("sat", 16'h7fff, OVF_EN);
    @(posedge clk);
    #1;

    // back-to-back vectors under a 5-cycle stall
    out_ready = 1'b0;
    send(16'h1000, 16'h2000, 1'b0, 1'b0);
    send(16'h1000, 16'h2000, 1'b1, 1'b0);
    send(16'h0400, 16'h2000, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_a = 16'h0400;
    in_b = 16'h2000;
    in_last = 1'b1;
    #1;
    chk("stall_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_data", out_data, 16'h2000);
      chk("stall_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_res("second", 16'h0800, 1'b0);
    @(posedge clk);
    #1;

    // reset mid-vector drops the partial sum
    send(16'h2000, 16'h2000, 1'b0, 1'b0);
    send(16'h2000, 16'h2000, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(16'h0800, 16'h2000, 1'b1, 1'b0);
    wait_res("after_rst", 16'h0800, 1'b0);
    @(posedge clk);
    #1;

    // random vectors, gaps and backpressure
    for (int v = 0; v < 60; v++) begin
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        send(rnd_op(), rnd_op(), i == len - 1, 1'b1);
        if ($urandom_range(0, 3) == 0)
          idle($urandom_range(1, 3));
      end
    end

    // drain
    out_ready = 1'b1;
    in_valid = 1'b0;
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
